// File: rtl/imem_loader.sv
// imem_loader: program loader for the RISC-V core's instruction memory.
//
// The host streams a length word N followed by N instruction words over a
// valid/ready handshake. Each instruction word is written to instruction
// memory at consecutive word addresses starting at 0. The core is held in
// reset for the whole load plus a short hold period, then released.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   in_valid    host word valid
//   in_data     host word (length word or instruction)
//   in_ready    loader accepts a word this cycle (depends on state only)
//   reload      single-cycle pulse, restarts the load from DONE or ERR
//   imem_we     instruction memory write enable (registered)
//   imem_addr   instruction memory word address (registered)
//   imem_wdata  instruction memory write data (registered)
//   cpu_reset   active-high reset to the core
//   load_done   high while the core is released
//   err         length word exceeded the memory depth
module imem_loader #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              err
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
  localparam logic [7:0]      HOLD_INIT = 8'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_WAIT_LEN,
    S_LOAD,
    S_DRAIN,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_cnt_reg, addr_cnt_next;
  // One bit wider than the address so a full-depth length fits.
  logic [ADDR_W:0]   remaining_reg, remaining_next;
  logic [7:0]        hold_cnt_reg, hold_cnt_next;

  logic              imem_we_reg;
  logic [ADDR_W-1:0] imem_addr_reg;
  logic [DATA_W-1:0] imem_wdata_reg;
  logic              cpu_reset_reg, cpu_reset_next;
  logic              load_done_reg, load_done_next;
  logic              err_reg, err_next;

  logic              xfer;
  logic              load_we;

  assign xfer    = in_valid && in_ready;
  assign load_we = (state_reg == S_LOAD) && xfer;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_WAIT_LEN;
      addr_cnt_reg   <= '0;
      remaining_reg  <= '0;
      hold_cnt_reg   <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      cpu_reset_reg  <= 1'b1;
      load_done_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_cnt_reg  <= addr_cnt_next;
      remaining_reg <= remaining_next;
      hold_cnt_reg  <= hold_cnt_next;
      // Write strobe is a one-cycle echo of each LOAD handshake; address
      // and data hold their last value on idle cycles.
      imem_we_reg   <= load_we;
      if (load_we) begin
        imem_addr_reg  <= addr_cnt_reg;
        imem_wdata_reg <= in_data;
      end
      cpu_reset_reg <= cpu_reset_next;
      load_done_reg <= load_done_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next     = state_reg;
    addr_cnt_next  = addr_cnt_reg;
    remaining_next = remaining_reg;
    hold_cnt_next  = hold_cnt_reg;
    case (state_reg)
      S_WAIT_LEN: begin
        if (xfer) begin
          if (in_data == '0) begin
            state_next    = S_HOLD;
            hold_cnt_next = HOLD_INIT;
          end else if (in_data > DEPTH_W) begin
            state_next = S_ERR;
          end else begin
            state_next     = S_LOAD;
            remaining_next = in_data[ADDR_W:0];
            addr_cnt_next  = '0;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          addr_cnt_next  = addr_cnt_reg + ADDR_W'(1);
          remaining_next = remaining_reg - (ADDR_W + 1)'(1);
          if (remaining_reg == (ADDR_W + 1)'(1)) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_next    = S_HOLD;
        hold_cnt_next = HOLD_INIT;
      end
      S_HOLD: begin
        // Release is taken on the edge that sees the counter at zero, so the
        // core sees HOLD_CYCLES+1 cycles of HOLD before DONE.
        if (hold_cnt_reg == 8'd0) begin
          state_next = S_DONE;
        end else begin
          hold_cnt_next = hold_cnt_reg - 8'd1;
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_next     = S_WAIT_LEN;
          addr_cnt_next  = '0;
          remaining_next = '0;
          hold_cnt_next  = '0;
        end
      end
      default: begin
        state_next = S_WAIT_LEN;
      end
    endcase
  end

  // Outputs. Status flags are decoded from the next state so they change on
  // the same edge as the state they describe.
  always_comb begin
    in_ready       = (state_reg == S_WAIT_LEN) || (state_reg == S_LOAD);
    cpu_reset_next = (state_next != S_DONE);
    load_done_next = (state_next == S_DONE);
    err_next       = (state_next == S_ERR);
  end

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign load_done  = load_done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        reload = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  imem_loader #(.ADDR_W(6), .DATA_W(32), .HOLD_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .reload(reload),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .load_done(load_done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Edge counter: during the cycle after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc);
      $display("[TB] write addr=%0d data=%h cycle=%0d", imem_addr, imem_wdata, cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  // Called at a falling edge; returns at a falling edge with hs = index of
  // the rising edge that transferred the word.
  task automatic send_word(input logic [31:0] d, output int hs);
    hs = -1;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        hs = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (hs < 0) begin
      tests++;
      fails++;
      $display("FAIL send_word: no handshake for %h (got none, required one within 40 cycles)", d);
    end else begin
      $display("[TB] handshake data=%h edge=%0d", d, hs);
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      if (load_done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dc < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done: load_done never rose (got 0, required 1 within 200 cycles)");
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);  // reset still low here
    tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %b required 1", cpu_reset); end
    tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we: got %b required 0", imem_we); end
    tests++; if ({imem_addr, imem_wdata} !== 38'h0) begin fails++; $display("FAIL reset_addr_data: got %h/%h required 0/0", imem_addr, imem_wdata); end
    tests++; if ({load_done, err} !== 2'b00) begin fails++; $display("FAIL reset_done_err: got %b%b required 00", load_done, err); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    #5 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int hs[4];
    int dc;
    logic [31:0] w[3];
    w[0] = 32'h00500093;
    w[1] = 32'h00A00113;
    w[2] = 32'h002081B3;
    clear_log();
    send_word(32'd3, hs[0]);
    for (int i = 0; i < 3; i++) send_word(w[i], hs[i+1]);
    wait_done(dc);
    tests++; if (wa_q.size() != 3) begin fails++; $display("FAIL basic_count: got %0d writes required 3", wa_q.size()); end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      tests++; if (wa_q[i] !== 6'(i) || wd_q[i] !== w[i]) begin fails++; $display("FAIL basic_write%0d: got %0d/%h required %0d/%h", i, wa_q[i], wd_q[i], i, w[i]); end
      tests++; if (wc_q[i] != hs[i+1]) begin fails++; $display("FAIL basic_latency%0d: got cycle %0d required %0d", i, wc_q[i], hs[i+1]); end
    end
    tests++; if (dc != hs[3] + 6) begin fails++; $display("FAIL basic_done_time: got edge %0d required %0d", dc, hs[3] + 6); end
    tests++; if (cpu_reset !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL basic_done_outputs: got cpu_reset=%b in_ready=%b required 0 0", cpu_reset, in_ready); end
  endtask

  task automatic test_backpressure();
    int hs[3];
    int dc;
    pulse_reload();
    tests++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL bp_reload: got cpu_reset=%b load_done=%b required 1 0", cpu_reset, load_done); end
    clear_log();
    send_word(32'd2, hs[0]);
    send_word(32'hA5A5_0001, hs[1]);
    repeat (3) @(negedge clk);
    send_word(32'hA5A5_0002, hs[2]);
    wait_done(dc);
    tests++; if (wa_q.size() != 2) begin fails++; $display("FAIL bp_count: got %0d writes required 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      tests++; if (wc_q[0] != hs[1] || wc_q[1] != hs[2]) begin fails++; $display("FAIL bp_timing: got %0d,%0d required %0d,%0d", wc_q[0], wc_q[1], hs[1], hs[2]); end
      tests++; if (wa_q[1] !== 6'd1 || wd_q[1] !== 32'hA5A5_0002) begin fails++; $display("FAIL bp_write1: got %0d/%h required 1/a5a50002", wa_q[1], wd_q[1]); end
    end
  endtask

  task automatic test_full_depth();
    int hs;
    int dc;
    int bad;
    pulse_reload();
    clear_log();
    send_word(32'd64, hs);
    for (int i = 0; i < 64; i++) send_word(32'(i), hs);
    wait_done(dc);
    tests++; if (wa_q.size() != 64) begin fails++; $display("FAIL full_count: got %0d writes required 64", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] !== 6'(i) || wd_q[i] !== 32'(i)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL full_data: got %0d bad writes required 0", bad); end
    if (wa_q.size() > 0) begin
      tests++; if (wa_q[wa_q.size()-1] !== 6'd63 || wd_q[wd_q.size()-1] !== 32'd63) begin fails++; $display("FAIL full_last: got %0d/%0d required 63/63", wa_q[wa_q.size()-1], wd_q[wd_q.size()-1]); end
    end
    tests++; if (load_done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL full_done: got load_done=%b err=%b required 1 0", load_done, err); end
  endtask

  task automatic test_overflow();
    int hs;
    pulse_reload();
    clear_log();
    send_word(32'd65, hs);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b required 1", err); end
    tests++; if (in_ready !== 1'b0 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL ovf_outputs: got ready=%b cpu_reset=%b done=%b required 0 1 0", in_ready, cpu_reset, load_done); end
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    tests++; if (wa_q.size() != 0 || err !== 1'b1 || cpu_reset !== 1'b1) begin fails++; $display("FAIL ovf_stuck: got writes=%0d err=%b cpu_reset=%b required 0 1 1", wa_q.size(), err, cpu_reset); end
    pulse_reload();
    tests++; if (err !== 1'b0 || in_ready !== 1'b1 || cpu_reset !== 1'b1) begin fails++; $display("FAIL ovf_reload: got err=%b ready=%b cpu_reset=%b required 0 1 1", err, in_ready, cpu_reset); end
  endtask

  task automatic test_zero_len();
    int hs;
    int dc;
    clear_log();
    send_word(32'd0, hs);
    wait_done(dc);
    tests++; if (dc != hs + 5) begin fails++; $display("FAIL zero_done_time: got edge %0d required %0d", dc, hs + 5); end
    tests++; if (wa_q.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d required 0", wa_q.size()); end
  endtask

  task automatic test_reload();
    int hs;
    int dc;
    pulse_reload();
    tests++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL rl_after: got cpu_reset=%b load_done=%b required 1 0", cpu_reset, load_done); end
    clear_log();
    send_word(32'd1, hs);
    send_word(32'hDEADBEEF, hs);
    wait_done(dc);
    tests++; if (wa_q.size() != 1 || wa_q[0] !== 6'd0 || wd_q[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL rl_write: got n=%0d first=%0d/%h required 1 0/deadbeef", wa_q.size(), wa_q.size() > 0 ? wa_q[0] : 6'd0, wd_q.size() > 0 ? wd_q[0] : 32'd0); end
    // A reload pulse in the middle of a load must be ignored.
    pulse_reload();
    clear_log();
    send_word(32'd2, hs);
    send_word(32'h0000_0011, hs);
    pulse_reload();
    send_word(32'h0000_0022, hs);
    wait_done(dc);
    tests++; if (wa_q.size() != 2) begin fails++; $display("FAIL rl_mid_count: got %0d writes required 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      tests++; if (wa_q[1] !== 6'd1 || wd_q[1] !== 32'h22) begin fails++; $display("FAIL rl_mid_write: got %0d/%h required 1/00000022", wa_q[1], wd_q[1]); end
    end
    tests++; if (dc != hs + 6) begin fails++; $display("FAIL rl_mid_done: got edge %0d required %0d", dc, hs + 6); end
  endtask

  task automatic test_async_reset();
    int hs;
    int dc;
    pulse_reload();
    clear_log();
    send_word(32'd4, hs);
    send_word(32'hCAFE_0000, hs);
    send_word(32'hCAFE_0001, hs);
    // Second write strobe is high now; assert reset away from any edge.
    #2 reset = 1'b0;
    #1;
    tests++; if (imem_we !== 1'b0 || cpu_reset !== 1'b1) begin fails++; $display("FAIL arst_immediate: got we=%b cpu_reset=%b required 0 1", imem_we, cpu_reset); end
    tests++; if (imem_addr !== 6'd0 || imem_wdata !== 32'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL arst_cleared: got addr=%0d data=%h ready=%b required 0 0 1", imem_addr, imem_wdata, in_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_log();
    send_word(32'd1, hs);
    send_word(32'h1234_5678, hs);
    wait_done(dc);
    tests++; if (wa_q.size() != 1 || wa_q[0] !== 6'd0 || wd_q[0] !== 32'h1234_5678) begin fails++; $display("FAIL arst_fresh_load: got n=%0d first=%0d/%h required 1 0/12345678", wa_q.size(), wa_q.size() > 0 ? wa_q[0] : 6'd0, wd_q.size() > 0 ? wd_q[0] : 32'd0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_depth();
    test_overflow();
    test_zero_len();
    test_reload();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader sitting between the bench/host and the RISC_V core's instruction memory.
- Accepts a word stream over a valid/ready interface: first a length word, then that many instruction words.
- Writes each instruction word into instruction memory at consecutive word addresses.
- Holds the core in reset until the load completes, then releases it. It is the writer end of the instruction-memory read path.

Parameters:
ADDR_W, 6, instruction memory word-address width; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction word width
HOLD_CYCLES, 4, cycles cpu_reset stays high after the last write before release (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
in_valid  in  1  host word valid
in_data  in  DATA_W  host word (length word or instruction)
in_ready  out  1  loader accepts word this cycle
reload  in  1  single-cycle pulse; restarts the load sequence (honoured only in DONE or ERR)
imem_we  out  1  instruction memory write enable (registered)
imem_addr  out  ADDR_W  word address (registered)
imem_wdata  out  DATA_W  write data (registered)
cpu_reset  out  1  active-high reset to RISC_V core
load_done  out  1  high while the core is released
err  out  1  length word exceeded DEPTH

Behaviour:
- Reset values (reset=0, async): state=WAIT_LEN, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, err=0, word counter=0, remaining=0.
- Handshake: a word transfers on a rising edge where in_valid=1 and in_ready=1. in_ready is a combinational function of state only, never of in_valid:
  - in_ready=1 in WAIT_LEN and LOAD.
  - in_ready=0 in DRAIN, HOLD, DONE and ERR.
- WAIT_LEN:
  - On transfer, latch N = in_data.
  - N=0: go to HOLD; no writes.
  - N>DEPTH: go to ERR. Compare the full DATA_W value, unsigned.
  - Otherwise: remaining=N, addr counter=0, go to LOAD.
- LOAD: each transfer registers imem_we=1, imem_addr=counter, imem_wdata=in_data on that edge.
  - Write latency: imem_we is high exactly in the cycle after the handshake edge.
  - Counter increments and remaining decrements per transfer.
  - On the transfer where remaining==1, go to DRAIN.
  - Cycles with no transfer: imem_we=0; imem_addr/imem_wdata hold their last value.
- DRAIN: one cycle while the final write is presented (imem_we=1). Then go to HOLD with the hold counter=HOLD_CYCLES.
- HOLD: imem_we=0, cpu_reset=1. Decrement the hold counter; when it reaches 0, go to DONE.
- DONE: cpu_reset=0, load_done=1 (both registered, asserted together). Remains in DONE indefinitely.
- ERR: err=1, cpu_reset=1, load_done=0, no memory writes. Exit only via reload or reset.
- reload:
  - In DONE or ERR: on the next edge go to WAIT_LEN, cpu_reset=1, load_done=0, err=0, counters cleared.
  - Ignored in all other states.
- Address wrap: cannot occur, since N<=DEPTH. With N=DEPTH the last write goes to address DEPTH-1.
- Reset mid-load: all state is cleared immediately. Memory contents are left as written. The host must resend from the length word.
- in_valid held high with in_ready=0: no transfer; data is neither consumed nor dropped by the loader.

Test Plan:
- Basic load: reset low 15 ns then high; send N=3, words 0x00500093, 0x00A00113, 0x002081B3 back-to-back. Required: 3 writes at addr 0,1,2 with matching data, each one cycle after its handshake. cpu_reset falls, load_done rises exactly 1(DRAIN)+4(HOLD)+1 cycles after the last write cycle begins.
- Backpressure gaps: N=2 with in_valid low 3 cycles between words. Required: imem_we pulses only in the cycle after each handshake; no duplicate writes.
- Full depth: N=64, data = address. Required: last write addr=63, data=63; then DONE. N=65 instead: err=1, in_ready=0, cpu_reset stays 1, no imem_we pulses.
- Zero length: N=0. Required: no writes; DONE after HOLD_CYCLES+1 cycles.
- Reload: from DONE, pulse reload, then send N=1, 0xDEADBEEF. Required: cpu_reset=1 and load_done=0 the cycle after reload; write addr 0; DONE again. A reload pulse during LOAD has no effect.
- Async reset mid-load: assert reset between clock edges after the 2nd of 4 words. Required: cpu_reset=1, imem_we=0, state WAIT_LEN immediately, without waiting for a clock edge. A fresh N=1 load then writes addr 0.
